// File: rtl/serdes_align_pkg.sv
// Shared types and helpers for the ISERDES bitslip word aligner.
package serdes_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED
    } align_state_e;

    localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'h01;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serdes_align_ch.sv
// Single-lane aligner: hunts for SYNC_PATTERN by pulsing bitslip, then holds lock.
module serdes_align_ch
    import serdes_align_pkg::*;
#(
    parameter int unsigned             WIDTH        = 8,
    parameter logic [WIDTH-1:0]        SYNC_PATTERN = WIDTH'(DEFAULT_SYNC_PATTERN),
    parameter int unsigned             SLIP_WAIT    = 3,
    parameter int unsigned             LOCK_CNT     = 16,
    localparam int unsigned            SCW          = clog2_min1(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             align_en_i,
    input  logic             realign_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bitslip_o,
    output logic             locked_o,
    output logic             align_fail_o,
    output logic [SCW-1:0]   slip_cnt_o
);

    localparam int unsigned WCW = clog2_min1(SLIP_WAIT + 1);
    localparam int unsigned TCW = clog2_min1(WIDTH + 1);
    localparam int unsigned MCW = clog2_min1(LOCK_CNT + 1);

    align_state_e   r_state, w_state;
    logic [WCW-1:0] r_wait, w_wait;
    logic [TCW-1:0] r_tries, w_tries;
    logic [SCW-1:0] r_slip, w_slip;
    logic [MCW-1:0] r_match, w_match;
    logic           r_fail, w_fail;
    logic           r_bitslip, r_locked;

    always_comb begin
        w_state = r_state;
        w_wait  = r_wait;
        w_tries = r_tries;
        w_slip  = r_slip;
        w_match = r_match;
        w_fail  = r_fail;
        case (r_state)
            IDLE: begin
                if (align_en_i) begin
                    w_state = SETTLE;
                    w_wait  = WCW'(SLIP_WAIT);
                    w_tries = '0;
                    w_slip  = '0;
                end
            end
            SETTLE: begin
                w_wait = r_wait - WCW'(1);
                if (r_wait <= WCW'(1)) begin
                    w_state = CHECK;
                    w_match = '0;
                end
            end
            CHECK: begin
                if (data_i == SYNC_PATTERN) begin
                    w_match = r_match + MCW'(1);
                    if (w_match == MCW'(LOCK_CNT)) w_state = LOCKED;
                end else begin
                    w_state = SLIP;
                    w_match = '0;
                end
            end
            SLIP: begin
                w_slip  = (r_slip == SCW'(WIDTH - 1)) ? '0 : r_slip + SCW'(1);
                w_tries = r_tries + TCW'(1);
                if (w_tries == TCW'(WIDTH)) begin
                    w_fail  = 1'b1;
                    w_tries = '0;
                end
                w_state = SETTLE;
                w_wait  = WCW'(SLIP_WAIT);
            end
            LOCKED: ;
            default: w_state = IDLE;
        endcase

        // Override order: realign restarts the hunt, but a disable beats it.
        if (realign_i) begin
            w_fail = 1'b0;
            if (r_state != IDLE) begin
                w_state = SETTLE;
                w_wait  = WCW'(SLIP_WAIT);
                w_tries = '0;
            end
        end
        if (!align_en_i) w_state = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_wait    <= '0;
            r_tries   <= '0;
            r_slip    <= '0;
            r_match   <= '0;
            r_fail    <= 1'b0;
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_wait    <= w_wait;
            r_tries   <= w_tries;
            r_slip    <= w_slip;
            r_match   <= w_match;
            r_fail    <= w_fail;
            r_bitslip <= (w_state == SLIP);
            r_locked  <= (w_state == LOCKED);
        end
    end

    assign bitslip_o    = r_bitslip;
    assign locked_o     = r_locked;
    assign align_fail_o = r_fail;
    assign slip_cnt_o   = r_slip;

endmodule

// File: rtl/serdes_bitslip_aligner.sv
// Multi-lane ISERDES word aligner: one independent aligner per lane plus a data pipeline stage.
module serdes_bitslip_aligner
    import serdes_align_pkg::*;
#(
    parameter int unsigned      NUM_CH       = 4,
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEFAULT_SYNC_PATTERN),
    parameter int unsigned      SLIP_WAIT    = 3,
    parameter int unsigned      LOCK_CNT     = 16,
    localparam int unsigned     SCW          = clog2_min1(WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    align_en_i,
    input  logic [NUM_CH-1:0]       realign_i,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    output logic [NUM_CH-1:0]       bitslip_o,
    output logic [NUM_CH-1:0]       locked_o,
    output logic [NUM_CH-1:0]       align_fail_o,
    output logic [NUM_CH*SCW-1:0]   slip_cnt_o,
    output logic [NUM_CH*WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]       data_valid_o
);

    logic [NUM_CH*WIDTH-1:0] r_data;
    logic [NUM_CH-1:0]       w_locked;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        serdes_align_ch #(
            .WIDTH        (WIDTH),
            .SYNC_PATTERN (SYNC_PATTERN),
            .SLIP_WAIT    (SLIP_WAIT),
            .LOCK_CNT     (LOCK_CNT)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .align_en_i   (align_en_i),
            .realign_i    (realign_i[g]),
            .data_i       (data_i[g*WIDTH +: WIDTH]),
            .bitslip_o    (bitslip_o[g]),
            .locked_o     (w_locked[g]),
            .align_fail_o (align_fail_o[g]),
            .slip_cnt_o   (slip_cnt_o[g*SCW +: SCW])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_data <= '0;
        else          r_data <= data_i;
    end

    assign data_o       = r_data;
    assign locked_o     = w_locked;
    assign data_valid_o = w_locked;

endmodule

// File: tb/tb_serdes_bitslip_aligner.sv
// Self-checking bench: ISERDES rotation model with 2-cycle slip latency, timing derived from the aligner rules.
module tb_serdes_bitslip_aligner;

    localparam int NUM_CH = 4;
    localparam int W      = 4;
    localparam int SW     = 3;
    localparam int LC     = 4;
    localparam int SCW    = 2;
    localparam logic [W-1:0] SYNC = 4'h1;
    // Cycles from the trigger edge to lock with k slips: SETTLE + CHECK + 1, plus (CHECK+SLIP+SETTLE) per slip.
    localparam int BASE_LOCK = SW + LC + 1;
    localparam int PER_SLIP  = SW + 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    align_en;
    logic [NUM_CH-1:0]       realign;
    logic [NUM_CH*W-1:0]     din;
    logic [NUM_CH-1:0]       bitslip, locked, afail, dvalid;
    logic [NUM_CH*SCW-1:0]   scnt;
    logic [NUM_CH*W-1:0]     dout;

    serdes_bitslip_aligner #(
        .NUM_CH       (NUM_CH),
        .WIDTH        (W),
        .SYNC_PATTERN (SYNC),
        .SLIP_WAIT    (SW),
        .LOCK_CNT     (LC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .align_en_i   (align_en),
        .realign_i    (realign),
        .data_i       (din),
        .bitslip_o    (bitslip),
        .locked_o     (locked),
        .align_fail_o (afail),
        .slip_cnt_o   (scnt),
        .data_o       (dout),
        .data_valid_o (dvalid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ISERDES model: 0 = rotating training word, 1 = constant, 2 = random payload
    int         rot  [NUM_CH];
    int         mode [NUM_CH];
    logic [W-1:0] cval [NUM_CH];
    bit         pend1[NUM_CH];
    bit         pend2[NUM_CH];

    int n_tick;
    int pulses   [NUM_CH];
    int last_p   [NUM_CH];
    int min_gap  [NUM_CH];
    int lock_tick[NUM_CH];
    int slip_while_locked;
    int dout_err;
    int dv_err;

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int r);
        logic [W-1:0] x;
        x = v;
        for (int i = 0; i < (r % W); i++) x = {x[W-2:0], x[W-1]};
        return x;
    endfunction

    task automatic drive_data();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (mode[ch])
                0:       din[ch*W +: W] = rol(SYNC, rot[ch]);
                1:       din[ch*W +: W] = cval[ch];
                default: din[ch*W +: W] = W'($urandom);
            endcase
        end
    endtask

    task automatic setup_lanes(input int off[NUM_CH]);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rot[ch]   = (W - off[ch]) % W;
            mode[ch]  = 0;
            pend1[ch] = 0;
            pend2[ch] = 0;
        end
        drive_data();
    endtask

    task automatic clear_stats();
        n_tick = 0;
        slip_while_locked = 0;
        dout_err = 0;
        dv_err   = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pulses[ch]    = 0;
            last_p[ch]    = -1;
            min_gap[ch]   = 1000;
            lock_tick[ch] = -1;
        end
    endtask

    // Advance one cycle, observe outputs after the edge, and update the ISERDES model.
    task automatic tick();
        logic [NUM_CH*W-1:0] prev;
        prev = din;
        @(posedge clk);
        #1;
        n_tick++;
        if (dout !== prev) dout_err++;
        if (dvalid !== locked) dv_err++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bitslip[ch]) begin
                if (locked[ch]) slip_while_locked++;
                pulses[ch]++;
                if (last_p[ch] >= 0 && (n_tick - last_p[ch] - 1) < min_gap[ch])
                    min_gap[ch] = n_tick - last_p[ch] - 1;
                last_p[ch] = n_tick;
            end
            if (locked[ch] && lock_tick[ch] < 0) lock_tick[ch] = n_tick;
            if (pend2[ch]) rot[ch]++;
            pend2[ch] = pend1[ch];
            pend1[ch] = bitslip[ch];
        end
        drive_data();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        align_en = 1'b0;
        realign  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        align_en = 1'b1;
        realign  = '0;
        din      = (NUM_CH*W)'($urandom);
        #2;
        checks++; if (bitslip !== '0) begin failures++; $display("FAIL reset_bitslip got=%b exp=0", bitslip); end
        checks++; if (locked  !== '0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (afail   !== '0) begin failures++; $display("FAIL reset_fail got=%b exp=0", afail); end
        checks++; if (scnt    !== '0) begin failures++; $display("FAIL reset_slipcnt got=%h exp=0", scnt); end
        checks++; if (dout    !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (dvalid  !== '0) begin failures++; $display("FAIL reset_dvalid got=%b exp=0", dvalid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bitslip, locked, dout} !== '0) begin failures++; $display("FAIL reset_held got=%h exp=0", {bitslip, locked, dout}); end
        do_reset();
    endtask

    task automatic test_aligned();
        do_reset();
        setup_lanes('{0, 0, 0, 0});
        clear_stats();
        align_en = 1'b1;
        repeat (20) tick();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++; if (pulses[ch] != 0) begin failures++; $display("FAIL aligned_pulses lane%0d got=%0d exp=0", ch, pulses[ch]); end
            checks++; if (lock_tick[ch] != BASE_LOCK) begin failures++; $display("FAIL aligned_lock_time lane%0d got=%0d exp=%0d", ch, lock_tick[ch], BASE_LOCK); end
            checks++; if (scnt[ch*SCW +: SCW] !== 2'd0) begin failures++; $display("FAIL aligned_slipcnt lane%0d got=%0d exp=0", ch, scnt[ch*SCW +: SCW]); end
        end
        for (int ch = 0; ch < NUM_CH; ch++) mode[ch] = 2;
        drive_data();
        repeat (15) tick();
        checks++; if (locked !== '1) begin failures++; $display("FAIL payload_keeps_lock got=%b exp=1111", locked); end
        checks++; if (slip_while_locked != 0) begin failures++; $display("FAIL payload_no_slip got=%0d exp=0", slip_while_locked); end
        checks++; if (dout_err != 0) begin failures++; $display("FAIL data_pipeline got=%0d exp=0 errors", dout_err); end
        checks++; if (dv_err != 0) begin failures++; $display("FAIL data_valid_eq_locked got=%0d exp=0 errors", dv_err); end
    endtask

    task automatic run_offsets(input int off[NUM_CH], input string name);
        do_reset();
        setup_lanes(off);
        clear_stats();
        align_en = 1'b1;
        repeat (BASE_LOCK + PER_SLIP * (W - 1) + 6) tick();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++; if (pulses[ch] != off[ch]) begin failures++; $display("FAIL %s_pulses lane%0d got=%0d exp=%0d", name, ch, pulses[ch], off[ch]); end
            checks++; if (lock_tick[ch] != BASE_LOCK + PER_SLIP * off[ch]) begin failures++; $display("FAIL %s_lock_time lane%0d got=%0d exp=%0d", name, ch, lock_tick[ch], BASE_LOCK + PER_SLIP * off[ch]); end
            checks++; if (scnt[ch*SCW +: SCW] !== SCW'(off[ch])) begin failures++; $display("FAIL %s_slipcnt lane%0d got=%0d exp=%0d", name, ch, scnt[ch*SCW +: SCW], off[ch]); end
            checks++; if (min_gap[ch] < SW + 1) begin failures++; $display("FAIL %s_pulse_gap lane%0d got=%0d exp>=%0d", name, ch, min_gap[ch], SW + 1); end
        end
        checks++; if (dout_err != 0) begin failures++; $display("FAIL %s_data_pipeline got=%0d exp=0 errors", name, dout_err); end
    endtask

    task automatic test_offset();
        int off[NUM_CH];
        off[0] = 2;
        for (int ch = 1; ch < NUM_CH; ch++) off[ch] = $urandom_range(0, W - 1);
        run_offsets(off, "offset");
        for (int ch = 0; ch < NUM_CH; ch++) off[ch] = $urandom_range(0, W - 1);
        run_offsets(off, "offset_rand");
    endtask

    task automatic test_fail();
        int i;
        do_reset();
        setup_lanes('{0, 0, 0, 0});
        mode[0] = 1;
        cval[0] = 4'hA;
        drive_data();
        clear_stats();
        align_en = 1'b1;
        for (i = 0; i < 60 && pulses[0] < 3; i++) tick();
        checks++; if (pulses[0] != 3) begin failures++; $display("FAIL fail_wait3 got=%0d exp=3 pulses", pulses[0]); end
        checks++; if (afail[0] !== 1'b0) begin failures++; $display("FAIL fail_early got=%b exp=0", afail[0]); end
        for (i = 0; i < 20 && pulses[0] < 4; i++) tick();
        tick();
        checks++; if (afail[0] !== 1'b1) begin failures++; $display("FAIL fail_after4 got=%b exp=1", afail[0]); end
        repeat (12) tick();
        checks++; if (pulses[0] != n_tick / PER_SLIP) begin failures++; $display("FAIL fail_keeps_hunting got=%0d exp=%0d", pulses[0], n_tick / PER_SLIP); end
        checks++; if (lock_tick[0] != -1 || locked[0] !== 1'b0) begin failures++; $display("FAIL fail_no_lock got=%0d exp=-1", lock_tick[0]); end
        checks++; if (afail[3:1] !== 3'b000) begin failures++; $display("FAIL fail_other_lanes got=%b exp=000", afail[3:1]); end
        checks++; if (min_gap[0] < SW + 1) begin failures++; $display("FAIL fail_pulse_gap got=%0d exp>=%0d", min_gap[0], SW + 1); end
    endtask

    task automatic test_realign();
        int i;
        cval[0] = SYNC;
        drive_data();
        for (i = 0; i < 40 && !locked[0]; i++) tick();
        checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL realign_prelock got=%b exp=1", locked[0]); end
        checks++; if (afail[0] !== 1'b1) begin failures++; $display("FAIL fail_sticky_on_lock got=%b exp=1", afail[0]); end
        clear_stats();
        realign = 4'b0001;
        tick();
        realign = '0;
        checks++; if (locked[0] !== 1'b0) begin failures++; $display("FAIL realign_unlock got=%b exp=0", locked[0]); end
        checks++; if (afail[0] !== 1'b0) begin failures++; $display("FAIL realign_clear_fail got=%b exp=0", afail[0]); end
        repeat (15) tick();
        checks++; if (lock_tick[0] != BASE_LOCK) begin failures++; $display("FAIL realign_relock got=%0d exp=%0d", lock_tick[0], BASE_LOCK); end
        checks++; if (pulses[0] != 0) begin failures++; $display("FAIL realign_pulses got=%0d exp=0", pulses[0]); end
        checks++; if (locked[3:1] !== 3'b111) begin failures++; $display("FAIL realign_others got=%b exp=111", locked[3:1]); end
    endtask

    task automatic test_multi();
        int k[NUM_CH];
        run_offsets('{0, 1, 3, 2}, "multi");
        do_reset();
        setup_lanes('{0, 1, 3, 2});
        clear_stats();
        align_en = 1'b1;
        repeat (6) tick();
        align_en = 1'b0;
        tick();
        checks++; if (locked !== '0 || bitslip !== '0) begin failures++; $display("FAIL disable_idle got=%b/%b exp=0/0", locked, bitslip); end
        clear_stats();
        repeat (20) tick();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++; if (pulses[ch] != 0 || lock_tick[ch] != -1) begin failures++; $display("FAIL disable_quiet lane%0d got=%0d/%0d exp=0/-1", ch, pulses[ch], lock_tick[ch]); end
            k[ch] = (W - (rot[ch] % W)) % W;
        end
        clear_stats();
        align_en = 1'b1;
        repeat (BASE_LOCK + PER_SLIP * (W - 1) + 4) tick();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++; if (pulses[ch] != k[ch] || lock_tick[ch] != BASE_LOCK + PER_SLIP * k[ch]) begin
                failures++; $display("FAIL reenable lane%0d got=%0d@%0d exp=%0d@%0d", ch, pulses[ch], lock_tick[ch], k[ch], BASE_LOCK + PER_SLIP * k[ch]); end
        end
    endtask

    task automatic test_reset_slip();
        int i;
        do_reset();
        setup_lanes('{2, 0, 0, 0});
        clear_stats();
        align_en = 1'b1;
        for (i = 0; i < 40 && !(bitslip[0] && pulses[0] == 2); i++) tick();
        checks++; if (!(bitslip[0] && locked[1])) begin failures++; $display("FAIL rst_slip_setup got=%b/%b exp=1/1", bitslip[0], locked[1]); end
        rst_n = 1'b0;
        #2;
        checks++; if (bitslip !== '0) begin failures++; $display("FAIL rst_slip_bitslip got=%b exp=0", bitslip); end
        checks++; if (locked !== '0 || dvalid !== '0) begin failures++; $display("FAIL rst_slip_locked got=%b/%b exp=0/0", locked, dvalid); end
        repeat (2) @(negedge clk);
        setup_lanes('{2, 0, 0, 0});
        rst_n = 1'b1;
        clear_stats();
        repeat (BASE_LOCK + PER_SLIP * 2 + 4) tick();
        checks++; if (pulses[0] != 2 || lock_tick[0] != BASE_LOCK + PER_SLIP * 2) begin failures++; $display("FAIL rst_restart lane0 got=%0d@%0d exp=2@%0d", pulses[0], lock_tick[0], BASE_LOCK + PER_SLIP * 2); end
        checks++; if (lock_tick[1] != BASE_LOCK) begin failures++; $display("FAIL rst_restart lane1 got=%0d exp=%0d", lock_tick[1], BASE_LOCK); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset();
        test_fail();
        test_realign();
        test_multi();
        test_reset_slip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
